// File: rtl/sobel_window_feeder_if.sv
// Handshake/bus bundle between the frame sequencer and its pixel memory,
// gradient core and result memory.
interface sobel_window_feeder_if #(
    parameter int unsigned PIX_W  = 16,
    parameter int unsigned RES_W  = 16,
    parameter int unsigned ADDR_W = 20
);
    logic              go;
    logic              busy;
    logic              done;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [PIX_W-1:0]  rd_data;
    logic [PIX_W-1:0]  px11, px21, px31, px12, px22, px32, px13, px23, px33;
    logic              start;
    logic              data_occur;
    logic [RES_W-1:0]  dxy;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [RES_W-1:0]  wr_data;
    logic [15:0]       miss_count;

    modport master (
        input  go, rd_data, data_occur, dxy,
        output busy, done, rd_en, rd_addr,
        output px11, px21, px31, px12, px22, px32, px13, px23, px33,
        output start, wr_en, wr_addr, wr_data, miss_count
    );

    modport slave (
        output go, rd_data, data_occur, dxy,
        input  busy, done, rd_en, rd_addr,
        input  px11, px21, px31, px12, px22, px32, px13, px23, px33,
        input  start, wr_en, wr_addr, wr_data, miss_count
    );
endinterface

// File: rtl/sobel_window_feeder.sv
// Frame sequencer: reads 3x3 windows from pixel memory, fires the gradient
// core once per window and stores each result at its window index.
module sobel_window_feeder #(
    parameter int unsigned NUM_WORDS = 589824,
    parameter int unsigned PIX_W     = 16,
    parameter int unsigned RES_W     = 16,
    parameter int unsigned ADDR_W    = 20,
    parameter int unsigned TIMEOUT   = 16
) (
    input logic                   clk,
    input logic                   reset,
    sobel_window_feeder_if.master bus
);
    localparam int unsigned TO_W       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit          HAS_WINDOW = (NUM_WORDS >= 9);

    typedef enum logic [2:0] {IDLE, FETCH, LAST, FIRE, WAIT, WRITE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] win;
    logic [3:0]        cnt;
    logic [TO_W-1:0]   wcnt;
    logic [PIX_W-1:0]  stage [0:7];
    logic              last_window_c;

    // Next window would need words base+9 .. base+17; stop if that runs past the frame.
    assign last_window_c = (64'(base) + 64'd18) > 64'(NUM_WORDS);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state           <= IDLE;
            base            <= '0;
            win             <= '0;
            cnt             <= '0;
            wcnt            <= '0;
            for (int i = 0; i < 8; i++) stage[i] <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.rd_en       <= 1'b0;
            bus.rd_addr     <= '0;
            bus.px11        <= '0;
            bus.px21        <= '0;
            bus.px31        <= '0;
            bus.px12        <= '0;
            bus.px22        <= '0;
            bus.px32        <= '0;
            bus.px13        <= '0;
            bus.px23        <= '0;
            bus.px33        <= '0;
            bus.start       <= 1'b0;
            bus.wr_en       <= 1'b0;
            bus.wr_addr     <= '0;
            bus.wr_data     <= '0;
            bus.miss_count  <= '0;
        end else begin
            bus.start <= 1'b0;
            bus.done  <= 1'b0;
            bus.wr_en <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.go) begin
                        base           <= '0;
                        win            <= '0;
                        bus.miss_count <= '0;
                        if (HAS_WINDOW) begin
                            state       <= FETCH;
                            cnt         <= '0;
                            bus.busy    <= 1'b1;
                            bus.rd_en   <= 1'b1;
                            bus.rd_addr <= '0;
                        end else begin
                            bus.done <= 1'b1;
                        end
                    end
                end

                // Word issued on cycle cnt-1 returns on cycle cnt.
                FETCH: begin
                    if (cnt != 4'd0) stage[3'(cnt - 4'd1)] <= bus.rd_data;
                    if (cnt == 4'd8) begin
                        bus.rd_en <= 1'b0;
                        state     <= LAST;
                    end else begin
                        cnt         <= cnt + 4'd1;
                        bus.rd_addr <= bus.rd_addr + ADDR_W'(1);
                    end
                end

                // Column-major packing; word 8 is still on the read bus.
                LAST: begin
                    bus.px11  <= stage[0];
                    bus.px21  <= stage[1];
                    bus.px31  <= stage[2];
                    bus.px12  <= stage[3];
                    bus.px22  <= stage[4];
                    bus.px32  <= stage[5];
                    bus.px13  <= stage[6];
                    bus.px23  <= stage[7];
                    bus.px33  <= bus.rd_data;
                    bus.start <= 1'b1;
                    state     <= FIRE;
                end

                FIRE: begin
                    wcnt  <= '0;
                    state <= WAIT;
                end

                WAIT: begin
                    if (bus.data_occur) begin
                        bus.wr_data <= bus.dxy;
                        bus.wr_en   <= 1'b1;
                        bus.wr_addr <= win;
                        state       <= WRITE;
                    end else if (wcnt == TO_W'(TIMEOUT - 1)) begin
                        if (bus.miss_count != 16'hFFFF) bus.miss_count <= bus.miss_count + 16'd1;
                        win  <= win + ADDR_W'(1);
                        base <= base + ADDR_W'(9);
                        if (last_window_c) begin
                            state    <= IDLE;
                            bus.busy <= 1'b0;
                            bus.done <= 1'b1;
                        end else begin
                            state       <= FETCH;
                            cnt         <= '0;
                            bus.rd_en   <= 1'b1;
                            bus.rd_addr <= base + ADDR_W'(9);
                        end
                    end else begin
                        wcnt <= wcnt + TO_W'(1);
                    end
                end

                WRITE: begin
                    win  <= win + ADDR_W'(1);
                    base <= base + ADDR_W'(9);
                    if (last_window_c) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                    end else begin
                        state       <= FETCH;
                        cnt         <= '0;
                        bus.rd_en   <= 1'b1;
                        bus.rd_addr <= base + ADDR_W'(9);
                    end
                end

                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sobel_window_feeder.sv
// Directed bench for sobel_window_feeder: a 29-word frame (three windows plus
// a two-word tail) with a scripted core response per window.
module tb_sobel_window_feeder;
    localparam int unsigned NW = 29;
    localparam int unsigned TO = 4;

    logic clk = 1'b0;
    logic reset;

    sobel_window_feeder_if #(.PIX_W(16), .RES_W(16), .ADDR_W(20)) bus ();

    sobel_window_feeder #(
        .NUM_WORDS(NW), .PIX_W(16), .RES_W(16), .ADDR_W(20), .TIMEOUT(TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Pixel memory: word a holds a+1, one-cycle read latency.
    always @(posedge clk) begin
        if (bus.rd_en === 1'b1) bus.rd_data <= 16'(bus.rd_addr + 20'd1);
    end

    // Event counters sampled mid-cycle.
    int          wr_cnt   = 0;
    int          done_cnt = 0;
    int unsigned max_rd   = 0;
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) wr_cnt <= wr_cnt + 1;
        if (bus.done === 1'b1) done_cnt <= done_cnt + 1;
        if (bus.rd_en === 1'b1 && 32'(bus.rd_addr) > max_rd) max_rd <= 32'(bus.rd_addr);
    end

    logic [8:0][15:0] pxv;
    assign pxv = {bus.px33, bus.px23, bus.px13, bus.px32, bus.px22,
                  bus.px12, bus.px31, bus.px21, bus.px11};

    typedef struct {
        int               win;
        int               m;       // WAIT cycle of data_occur, -1 = no response
        logic [15:0]      dxy;
        bit               spur;    // data_occur held high from FETCH on
        bit               go_mid;  // pulse go while busy
        bit               last;
        logic [15:0]      miss;    // miss_count after this window
        int               exp_wr;  // writes in the whole pass (last row only)
        logic [8:0][15:0] px;      // px11,px21,px31,px12,px22,px32,px13,px23,px33 at [0..8]
    } vec_t;

    vec_t tbl [6];
    int   checks   = 0;
    int   failures = 0;
    int   t        = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic wait_start();
        int n;
        n = 0;
        while (bus.start !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        if (bus.start !== 1'b1) check("start_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},    32'(bus.busy), 32'd0);
        check({tag, "_done"},    32'(bus.done), 32'd0);
        check({tag, "_rd_en"},   32'(bus.rd_en), 32'd0);
        check({tag, "_rd_addr"}, 32'(bus.rd_addr), 32'd0);
        check({tag, "_start"},   32'(bus.start), 32'd0);
        check({tag, "_wr_en"},   32'(bus.wr_en), 32'd0);
        check({tag, "_wr_addr"}, 32'(bus.wr_addr), 32'd0);
        check({tag, "_wr_data"}, 32'(bus.wr_data), 32'd0);
        check({tag, "_miss"},    32'(bus.miss_count), 32'd0);
        check({tag, "_px_or"},   32'(|pxv), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int s;
        int wr0;
        int dn0;

        tbl[0] = '{0,  2, 16'h0123, 1'b0, 1'b0, 1'b0, 16'd0, 0,
                   {16'd9, 16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1}};
        tbl[1] = '{1, -1, 16'h0000, 1'b0, 1'b0, 1'b0, 16'd1, 0,
                   {16'd18, 16'd17, 16'd16, 16'd15, 16'd14, 16'd13, 16'd12, 16'd11, 16'd10}};
        tbl[2] = '{2,  0, 16'h0BEE, 1'b1, 1'b0, 1'b1, 16'd1, 2,
                   {16'd27, 16'd26, 16'd25, 16'd24, 16'd23, 16'd22, 16'd21, 16'd20, 16'd19}};
        tbl[3] = '{0,  1, 16'h1111, 1'b0, 1'b0, 1'b0, 16'd0, 0,
                   {16'd9, 16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1}};
        tbl[4] = '{1,  3, 16'h2222, 1'b0, 1'b1, 1'b0, 16'd0, 0,
                   {16'd18, 16'd17, 16'd16, 16'd15, 16'd14, 16'd13, 16'd12, 16'd11, 16'd10}};
        tbl[5] = '{2,  0, 16'h3333, 1'b0, 1'b0, 1'b1, 16'd0, 3,
                   {16'd27, 16'd26, 16'd25, 16'd24, 16'd23, 16'd22, 16'd21, 16'd20, 16'd19}};

        reset          = 1'b0;
        bus.go         = 1'b0;
        bus.data_occur = 1'b0;
        bus.dxy        = '0;
        s   = 0;
        wr0 = 0;
        dn0 = 0;
        for (int i = 0; i < 3; i++) step();
        check_all_zero("reset");
        reset = 1'b1;
        step();

        for (int i = 0; i < 6; i++) begin
            if (tbl[i].win == 0) begin
                wr0    = wr_cnt;
                dn0    = done_cnt;
                bus.go = 1'b1;
                t      = 0;
                step();
                bus.go = 1'b0;
                check($sformatf("busy_after_go_r%0d", i), 32'(bus.busy), 32'd1);
                check($sformatf("rd_addr_first_r%0d", i), 32'(bus.rd_addr), 32'd0);
            end
            if (tbl[i].spur) begin
                bus.data_occur = 1'b1;
                bus.dxy        = tbl[i].dxy;
            end
            if (tbl[i].go_mid) begin
                bus.go = 1'b1;
                step();
                bus.go = 1'b0;
            end
            wait_start();
            s = t;
            if (tbl[i].win == 0) check($sformatf("start_cycle_r%0d", i), 32'(t), 32'd11);
            for (int j = 0; j < 9; j++)
                check($sformatf("px%0d_r%0d", j, i), 32'(pxv[j]), 32'(tbl[i].px[j]));
            step();
            check($sformatf("start_one_cycle_r%0d", i), 32'(bus.start), 32'd0);

            if (tbl[i].m >= 0) begin
                for (int c = 0; c < tbl[i].m; c++) step();
                bus.data_occur = 1'b1;
                bus.dxy        = tbl[i].dxy;
                step();
                if (!tbl[i].spur) bus.data_occur = 1'b0;
                check($sformatf("wr_en_r%0d", i), 32'(bus.wr_en), 32'd1);
                check($sformatf("wr_cycle_r%0d", i), 32'(t), 32'(s + 2 + tbl[i].m));
                check($sformatf("wr_addr_r%0d", i), 32'(bus.wr_addr), 32'(tbl[i].win));
                check($sformatf("wr_data_r%0d", i), 32'(bus.wr_data), 32'(tbl[i].dxy));
                step();
                bus.data_occur = 1'b0;
                if (tbl[i].last) begin
                    check($sformatf("done_r%0d", i), 32'(bus.done), 32'd1);
                    check($sformatf("busy_drop_r%0d", i), 32'(bus.busy), 32'd0);
                    step();
                    check($sformatf("done_one_cycle_r%0d", i), 32'(bus.done), 32'd0);
                    check($sformatf("wr_addr_hold_r%0d", i), 32'(bus.wr_addr), 32'(tbl[i].win));
                end else begin
                    check($sformatf("next_fetch_r%0d", i), 32'(bus.rd_en), 32'd1);
                    check($sformatf("next_addr_r%0d", i), 32'(bus.rd_addr), 32'(9 * (tbl[i].win + 1)));
                    check($sformatf("no_done_r%0d", i), 32'(bus.done), 32'd0);
                end
            end else begin
                for (int c = 0; c < int'(TO); c++) step();
                check($sformatf("to_fetch_r%0d", i), 32'(bus.rd_en), 32'd1);
                check($sformatf("to_addr_r%0d", i), 32'(bus.rd_addr), 32'(9 * (tbl[i].win + 1)));
            end
            check($sformatf("miss_r%0d", i), 32'(bus.miss_count), 32'(tbl[i].miss));

            if (tbl[i].last) begin
                step();
                check($sformatf("writes_pass_r%0d", i), 32'(wr_cnt - wr0), 32'(tbl[i].exp_wr));
                check($sformatf("dones_pass_r%0d", i), 32'(done_cnt - dn0), 32'd1);
                check($sformatf("max_rd_addr_r%0d", i), max_rd, 32'd26);
            end
        end

        // Reset in WAIT of window 1 abandons the pass.
        bus.go = 1'b1;
        t      = 0;
        step();
        bus.go = 1'b0;
        wait_start();
        step();
        bus.data_occur = 1'b1;
        bus.dxy        = 16'h0055;
        step();
        bus.data_occur = 1'b0;
        check("rst_pass_w0_write", 32'(bus.wr_en), 32'd1);
        wait_start();
        step();
        step();
        check("rst_pass_busy_before", 32'(bus.busy), 32'd1);
        reset = 1'b0;
        step();
        check_all_zero("midreset");
        reset = 1'b1;
        wr0   = wr_cnt;
        dn0   = done_cnt;
        for (int c = 0; c < 30; c++) step();
        check("post_reset_writes", 32'(wr_cnt - wr0), 32'd0);
        check("post_reset_dones", 32'(done_cnt - dn0), 32'd0);
        check("post_reset_busy", 32'(bus.busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
